// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - opcode, immediate-selector and NOP constants for the decode stage
package decode_stage_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_CSR       = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_sel_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// rtl/decode_stage_imm_gen.sv - combinational immediate extraction and sign extension
module imm_gen
  import decode_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     inst,
  input  imm_sel_t        imm_sel,
  output logic [XLEN-1:0] imm
);

  // Build the 32-bit signed value first so widening to XLEN is a plain sign extension.
  logic signed [31:0] raw;

  always_comb begin
    raw = '0;
    case (imm_sel)
      IMM_I:   raw = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   raw = {inst[31:12], 12'b0};
      IMM_J:   raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_Z:   raw = {27'b0, inst[19:15]};
      default: raw = '0;
    endcase
    imm = XLEN'(raw);
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - fetch->execute pipeline register with decode, load-use interlock and flush
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int          XLEN     = XLEN_DEFAULT,
  parameter logic [31:0] NOP_INST = decode_stage_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            flush,
  input  logic            ex_load_valid,
  input  logic [4:0]      ex_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic            add_rshift_type,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic     held_valid;
  logic     uses_rs1;
  logic     uses_rs2;
  logic     writes_rd;
  logic     supported;
  logic     hazard;
  imm_sel_t imm_sel;

  assign opcode          = out_inst[6:0];
  assign funct3          = out_inst[14:12];
  assign add_rshift_type = out_inst[30];

  always_comb begin
    imm_sel   = IMM_NONE;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    writes_rd = 1'b1;
    supported = 1'b1;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        imm_sel  = IMM_U;
        uses_rs1 = 1'b0;
      end
      OP_JAL: begin
        imm_sel  = IMM_J;
        uses_rs1 = 1'b0;
      end
      OP_JALR, OP_LOAD, OP_ARI_ITYPE: imm_sel = IMM_I;
      OP_CSR: begin
        // funct3[2] selects the immediate CSR forms, where the rs1 field is a 5-bit zimm
        if (funct3[2]) begin
          imm_sel  = IMM_Z;
          uses_rs1 = 1'b0;
        end else begin
          imm_sel = IMM_I;
        end
      end
      OP_STORE: begin
        imm_sel   = IMM_S;
        uses_rs2  = 1'b1;
        writes_rd = 1'b0;
      end
      OP_BRANCH: begin
        imm_sel   = IMM_B;
        uses_rs2  = 1'b1;
        writes_rd = 1'b0;
      end
      OP_ARI_RTYPE: uses_rs2 = 1'b1;
      default:      supported = 1'b0;
    endcase
  end

  assign rs1     = uses_rs1  ? out_inst[19:15] : 5'd0;
  assign rs2     = uses_rs2  ? out_inst[24:20] : 5'd0;
  assign rd      = writes_rd ? out_inst[11:7]  : 5'd0;
  assign illegal = held_valid & ~supported;

  assign hazard = held_valid & ex_load_valid & (ex_rd != 5'd0) &
                  ((uses_rs1 & (out_inst[19:15] == ex_rd)) |
                   (uses_rs2 & (out_inst[24:20] == ex_rd)));

  assign out_valid = held_valid & ~hazard & ~flush;
  assign in_ready  = flush | ~held_valid | (out_valid & out_ready);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst    (out_inst),
    .imm_sel (imm_sel),
    .imm     (imm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_valid <= 1'b0;
      out_pc     <= '0;
      out_inst   <= NOP_INST;
    end else if (flush) begin
      held_valid <= 1'b0;
      out_inst   <= NOP_INST;
    end else if (in_valid && in_ready) begin
      held_valid <= 1'b1;
      out_pc     <= in_pc;
      out_inst   <= in_inst;
    end else if (out_valid && out_ready) begin
      held_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and randomized checks of decode_stage against a behavioural model
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        ex_load_valid;
  logic [4:0]  ex_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        add_rshift_type;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  // Model of the stage: one slot holding {pc, inst} and whether it is occupied.
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;

  localparam logic [31:0] NOP = 32'h0000_0013;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .ex_load_valid(ex_load_valid), .ex_rd(ex_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .opcode(opcode), .funct3(funct3), .add_rshift_type(add_rshift_type),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Field meanings from the ISA, immediates rebuilt with weighted-bit arithmetic.
  task automatic ref_dec(input logic [31:0] i, output logic [4:0] r1, output logic [4:0] r2,
                         output logic [4:0] rdo, output logic [31:0] im, output bit legal,
                         output bit u1, output bit u2);
    bit wr;
    legal = 1; u1 = 1; u2 = 0; wr = 1; im = 0;
    case (i[6:0])
      7'h37, 7'h17: begin u1 = 0; im = i[31:12] * 4096; end
      7'h6F: begin
        u1 = 0;
        im = i[30:21] * 2 + i[20] * 2048 + i[19:12] * 4096 - (i[31] ? 32'h0010_0000 : 0);
      end
      7'h67, 7'h03, 7'h13: im = i[31:20] - (i[31] ? 4096 : 0);
      7'h73: begin
        if (i[14]) begin u1 = 0; im = i[19:15]; end
        else im = i[31:20] - (i[31] ? 4096 : 0);
      end
      7'h23: begin u2 = 1; wr = 0; im = i[31:25] * 32 + i[11:7] - (i[31] ? 4096 : 0); end
      7'h63: begin
        u2 = 1; wr = 0;
        im = i[11:8] * 2 + i[30:25] * 32 + i[7] * 2048 - (i[31] ? 4096 : 0);
      end
      7'h33: u2 = 1;
      default: legal = 0;
    endcase
    r1  = u1 ? i[19:15] : 5'd0;
    r2  = u2 ? i[24:20] : 5'd0;
    rdo = wr ? i[11:7]  : 5'd0;
  endtask

  task automatic model_outs(output bit ov, output bit ir);
    logic [4:0] r1, r2, rdo; logic [31:0] im; bit legal, u1, u2, haz;
    ref_dec(m_inst, r1, r2, rdo, im, legal, u1, u2);
    haz = m_valid && ex_load_valid && ex_rd != 0 &&
          ((u1 && m_inst[19:15] == ex_rd) || (u2 && m_inst[24:20] == ex_rd));
    ov = m_valid && !haz && !flush;
    ir = flush || !m_valid || (ov && out_ready);
  endtask

  task automatic check_all();
    logic [4:0] r1, r2, rdo; logic [31:0] im; bit legal, u1, u2, ov, ir;
    ref_dec(m_inst, r1, r2, rdo, im, legal, u1, u2);
    model_outs(ov, ir);
    chk("out_valid", out_valid, ov);
    chk("in_ready", in_ready, ir);
    chk("out_pc", out_pc, m_pc);
    chk("out_inst", out_inst, m_inst);
    chk("opcode", opcode, m_inst[6:0]);
    chk("funct3", funct3, m_inst[14:12]);
    chk("add_rshift_type", add_rshift_type, m_inst[30]);
    chk("rs1", rs1, r1);
    chk("rs2", rs2, r2);
    chk("rd", rd, rdo);
    chk("imm", imm, im);
    chk("illegal", illegal, m_valid && !legal);
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                       input bit fl, input bit exl, input logic [4:0] exr, input bit ordy);
    in_valid = v; in_pc = pc; in_inst = inst; flush = fl;
    ex_load_valid = exl; ex_rd = exr; out_ready = ordy;
    #1;
    check_all();
  endtask

  task automatic tick();
    bit ov, ir, n_valid; logic [31:0] n_pc, n_inst;
    model_outs(ov, ir);
    n_valid = m_valid; n_pc = m_pc; n_inst = m_inst;
    if (flush) begin n_valid = 0; n_inst = NOP; end
    else if (in_valid && ir) begin n_valid = 1; n_pc = in_pc; n_inst = in_inst; end
    else if (ov && out_ready) n_valid = 0;
    @(posedge clk);
    m_valid = n_valid; m_pc = n_pc; m_inst = n_inst;
    #1;
  endtask

  task automatic feed(input logic [31:0] pc, input logic [31:0] inst);
    drive(1, pc, inst, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    logic [6:0] ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                             7'h23, 7'h13, 7'h33, 7'h73, 7'h7F, 7'h0F};
    logic [31:0] held;
    rst = 1; m_valid = 0; m_pc = 0; m_inst = NOP;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("reset_out_inst", out_inst, 32'h13);
    chk("reset_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 0;

    // Stream with out_ready held high: each accepted instruction drains next cycle.
    drive(1, 32'h100, 32'hFFB1_0093, 0, 0, 0, 1);
    tick();
    drive(1, 32'h104, 32'h0010_0113, 0, 0, 0, 1);
    chk("addi_valid", out_valid, 1);
    chk("addi_imm", imm, 32'hFFFF_FFFB);
    chk("addi_rs1", rs1, 2);
    chk("addi_rd", rd, 1);
    chk("addi_opcode", opcode, 7'h13);
    chk("stream_in_ready", in_ready, 1);
    tick();
    drive(1, 32'h108, 32'h0020_0193, 0, 0, 0, 1);
    chk("stream2_pc", out_pc, 32'h104);
    tick();

    // Backpressure for three cycles, then accept and drain together.
    held = m_inst;
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h200, 32'h0030_0213, 0, 0, 0, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_stable", out_inst, held);
      tick();
    end
    drive(1, 32'h200, 32'h0030_0213, 0, 0, 0, 1);
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_captured", out_pc, 32'h200);

    // Load-use on rs1 of add x3,x5,x6, then release, then ex_rd=0 never stalls.
    feed(32'h300, 32'h0062_81B3);
    for (int k = 0; k < 2; k++) begin
      drive(1, 32'h304, NOP, 0, 1, 5'd5, 1);
      chk("lu_out_valid", out_valid, 0);
      chk("lu_in_ready", in_ready, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 5'd5, 1);
    chk("lu_release", out_valid, 1);
    tick();
    feed(32'h310, 32'h0000_01B3);
    drive(0, 0, 0, 0, 1, 5'd0, 1);
    chk("lu_x0_nostall", out_valid, 1);
    tick();

    // Flush with a simultaneous input: the input is discarded.
    feed(32'h400, 32'h0062_81B3);
    drive(1, 32'h404, 32'h0010_0093, 1, 0, 0, 0);
    chk("flush_now_valid", out_valid, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("flush_after_valid", out_valid, 0);
    chk("flush_nop", out_inst, NOP);

    // Immediate formats.
    feed(32'h500, 32'h0051_2623);
    chk("sw_imm", imm, 12);
    chk("sw_rd", rd, 0);
    chk("sw_rs2", rs2, 5);
    tick();
    feed(32'h504, 32'hFE20_8CE3);
    chk("beq_imm", imm, 32'hFFFF_FFF8);
    tick();
    feed(32'h508, 32'h1234_50B7);
    chk("lui_imm", imm, 32'h1234_5000);
    chk("lui_rs1", rs1, 0);
    tick();
    feed(32'h50C, 32'h0010_006F);
    chk("jal_imm", imm, 32'h0000_0800);
    tick();
    feed(32'h510, 32'h4030_D093);
    chk("srai_type", add_rshift_type, 1);
    chk("srai_imm", imm[4:0], 3);
    tick();
    feed(32'h514, 32'h0000_007F);
    chk("illegal_7f", illegal, 1);
    chk("illegal_advances", out_valid, 1);
    tick();

    // Asynchronous reset while an instruction is held.
    feed(32'h600, 32'h0062_81B3);
    rst = 1; #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_inst", out_inst, NOP);
    chk("rst_async_illegal", illegal, 0);
    m_valid = 0; m_pc = 0; m_inst = NOP;
    @(posedge clk); #1;
    rst = 0;

    // Randomized traffic with small register numbers to provoke interlocks.
    for (int n = 0; n < 500; n++) begin
      logic [31:0] ri;
      ri = $urandom;
      ri[6:0]   = ops[$urandom_range(0, 11)];
      ri[19:15] = 5'($urandom_range(0, 7));
      ri[24:20] = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 3) != 0, $urandom, ri, $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
